// File: rtl/semafoare_pkg.sv
// Shared definitions for the traffic-light ring: state encoding and default timing.
package semafoare_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT, ST_CLEAR, ST_MAINT, ST_FAULT
  } stare_t;

  localparam logic [23:0] SEC_DEF       = 24'd10000000;
  localparam logic [7:0]  CLEAR_S_DEF   = 8'd2;
  localparam logic [7:0]  TIMEOUT_S_DEF = 8'd60;

  // States in which the yellow lamp flashes.
  function automatic logic clipeste(stare_t s);
    return (s == ST_MAINT) || (s == ST_FAULT);
  endfunction
endpackage

// File: rtl/generator_secunde.sv
// 1 s tick prescaler plus elapsed-seconds counter, restartable by clear.
module generator_secunde
  import semafoare_pkg::*;
#(
  parameter logic [23:0] SEC = SEC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  output logic       tick,
  output logic [7:0] seconds
);
  logic [23:0] presc;

  assign tick = (presc == SEC - 24'd1);

  // Prescaler wraps on tick; seconds advance once per tick; both restart on clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc   <= '0;
      seconds <= '0;
    end else if (tick) begin
      presc   <= '0;
      seconds <= seconds + 8'd1;
    end else begin
      presc   <= presc + 24'd1;
    end
  end
endmodule

// File: rtl/coordonator_semafoare.sv
// Ring coordinator: issues the cycle token, waits for its return with a watchdog,
// inserts all-red clearance, and handles maintenance and fault flashing.
module coordonator_semafoare
  import semafoare_pkg::*;
#(
  parameter logic [23:0] SEC       = SEC_DEF,
  parameter logic [7:0]  CLEAR_S   = CLEAR_S_DEF,
  parameter logic [7:0]  TIMEOUT_S = TIMEOUT_S_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intretinere,
  input  logic       Continuare_final,
  output logic       Start_ciclu,
  output logic       Rosu_general,
  output logic       Galben_intermitent,
  output logic       Mod_intretinere,
  output logic       Eroare,
  output logic [7:0] Nr_cicluri
);
  stare_t     state, next_state;
  logic       tok_q, tok_edge;
  logic       blink;
  logic       tick, clear;
  logic [7:0] seconds;

  // Timer restarts on every state change so each timed state is a whole number of seconds.
  assign clear    = (next_state != state);
  assign tok_edge = Continuare_final && !tok_q;

  generator_secunde #(.SEC(SEC)) u_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .tick    (tick),
    .seconds (seconds)
  );

  // Next-state selection; token edge has priority over the watchdog expiry.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (tick) next_state = intretinere ? ST_MAINT : ST_START;
      ST_START: next_state = ST_WAIT;
      ST_WAIT: begin
        if (tok_edge)                                   next_state = ST_CLEAR;
        else if (tick && seconds == TIMEOUT_S - 8'd1)   next_state = ST_FAULT;
      end
      ST_CLEAR: if (tick && seconds == CLEAR_S - 8'd1)
                  next_state = intretinere ? ST_MAINT : ST_START;
      ST_MAINT: if (!intretinere) next_state = ST_CLEAR;
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State, token edge register, cycle counter and flash phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tok_q      <= 1'b0;
      Nr_cicluri <= '0;
      blink      <= 1'b0;
    end else begin
      state <= next_state;
      tok_q <= Continuare_final;
      if (state == ST_WAIT && tok_edge) Nr_cicluri <= Nr_cicluri + 8'd1;
      if (!clipeste(next_state))  blink <= 1'b0;
      else if (clear)             blink <= 1'b1;
      else if (tick)              blink <= ~blink;
    end
  end

  assign Start_ciclu        = (state == ST_START);
  assign Rosu_general       = (state == ST_IDLE) || (state == ST_START) || (state == ST_CLEAR);
  assign Galben_intermitent = blink;
  assign Mod_intretinere    = (state == ST_MAINT);
  assign Eroare             = (state == ST_FAULT);
endmodule

// File: tb/tb_coordonator_semafoare.sv
// Randomized bench for the ring coordinator against a time-in-mode reference model.
module tb_coordonator_semafoare;
  localparam int SEC = 4, CL = 2, TO = 5;

  logic       clk = 1'b0, reset = 1'b1, intretinere = 1'b0, Continuare_final = 1'b0;
  logic       Start_ciclu, Rosu_general, Galben_intermitent, Mod_intretinere, Eroare;
  logic [7:0] Nr_cicluri;

  int n_chk = 0, n_err = 0;

  coordonator_semafoare #(.SEC(24'd4), .CLEAR_S(8'd2), .TIMEOUT_S(8'd5)) dut (
    .clk                (clk),
    .reset              (reset),
    .intretinere        (intretinere),
    .Continuare_final   (Continuare_final),
    .Start_ciclu        (Start_ciclu),
    .Rosu_general       (Rosu_general),
    .Galben_intermitent (Galben_intermitent),
    .Mod_intretinere    (Mod_intretinere),
    .Eroare             (Eroare),
    .Nr_cicluri         (Nr_cicluri)
  );

  always #5 clk = ~clk;

  // Reference model: current mode, cycles spent in it, completed rings, last token level.
  typedef enum {M_IDLE, M_START, M_WAIT, M_CLEAR, M_MAINT, M_FAULT} mod_t;
  mod_t m_mode = M_IDLE;
  int   m_el = 0, m_cnt = 0;
  bit   m_tok = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    mod_t nm;
    bit   edge_seen;
    if (reset) begin
      m_mode = M_IDLE; m_el = 0; m_cnt = 0; m_tok = 0;
      return;
    end
    edge_seen = Continuare_final && !m_tok;
    m_tok     = Continuare_final;
    nm        = m_mode;
    case (m_mode)
      M_IDLE:  if (m_el == SEC - 1) nm = intretinere ? M_MAINT : M_START;
      M_START: nm = M_WAIT;
      M_WAIT: begin
        if (edge_seen) begin nm = M_CLEAR; m_cnt = (m_cnt + 1) % 256; end
        else if (m_el == TO * SEC - 1) nm = M_FAULT;
      end
      M_CLEAR: if (m_el == CL * SEC - 1) nm = intretinere ? M_MAINT : M_START;
      M_MAINT: if (!intretinere) nm = M_CLEAR;
      default: nm = m_mode;
    endcase
    m_el   = (nm != m_mode) ? 0 : m_el + 1;
    m_mode = nm;
  endtask

  task automatic check_outputs();
    bit flash = (m_mode == M_MAINT || m_mode == M_FAULT) && ((m_el / SEC) % 2 == 0);
    chk("start",  Start_ciclu,        m_mode == M_START);
    chk("rosu",   Rosu_general,       m_mode == M_IDLE || m_mode == M_START || m_mode == M_CLEAR);
    chk("galben", Galben_intermitent, flash);
    chk("maint",  Mod_intretinere,    m_mode == M_MAINT);
    chk("eroare", Eroare,             m_mode == M_FAULT);
    chk("nr",     Nr_cicluri,         m_cnt);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit wrapped;
    int budget;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Ring run with a prompt token until the completed-cycle count wraps.
    wrapped = 0;
    budget  = 0;
    while (!wrapped && budget < 6000) begin
      Continuare_final = (m_mode == M_WAIT && m_el >= 1 && m_el <= 2);
      step();
      if (m_cnt == 0 && m_mode == M_CLEAR && budget > 100) wrapped = 1;
      budget++;
    end
    chk("wrap_seen", wrapped, 1'b1);
    chk("wrap_nr", Nr_cicluri, 8'd0);

    // Reset in the middle of WAIT with the token asserted; the token must be discarded.
    Continuare_final = 1'b0;
    budget = 0;
    while (m_mode != M_WAIT && budget < 50) begin step(); budget++; end
    chk("reach_wait", m_mode == M_WAIT, 1'b1);
    step(); step();
    reset = 1'b1; Continuare_final = 1'b1;
    step();
    chk("rst_rosu", Rosu_general, 1'b1);
    chk("rst_nr", Nr_cicluri, 8'd0);
    reset = 1'b0;
    repeat (30) step();
    chk("held_token_fault", Eroare, 1'b1);

    // Fault must ignore token and maintenance until reset.
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) Continuare_final = ~Continuare_final;
      if ($urandom_range(0, 4) == 0) intretinere = ~intretinere;
      step();
    end
    chk("fault_sticky", Eroare, 1'b1);
    reset = 1'b1; intretinere = 1'b0; Continuare_final = 1'b0;
    step();
    reset = 1'b0;

    // Random traffic: sporadic token toggles, maintenance requests and resets.
    repeat (3000) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0)  Continuare_final = ~Continuare_final;
      if ($urandom_range(0, 39) == 0) intretinere = ~intretinere;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
